register_bank_writer: RTL and testbench

Write side of the 8 x 16-bit register bank; the counterpart of the 8:1 read multiplexer. It accepts write requests over a valid/ready handshake and buffers them in a 2-entry FIFO. It decodes the 3-bit write address into a one-hot load enable and commits one write per enabled cycle into eight 16-bit registers. The eight register outputs drive the read multiplexer's eight data inputs directly.

---
 rtl/register_bank_writer.sv | 128 ++++++++++++
 tb/tb_register_bank_writer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/register_bank_writer.sv
// register_bank_writer
//   Write side of the 8 x WIDTH register bank. Write requests arrive over a
//   valid/ready handshake and are buffered in a 2-entry FIFO. Whenever
//   commit_enable is high and the FIFO holds an entry, the head entry is
//   popped and written into the addressed register. A registered one-hot copy
//   of the committed address is presented on load_enable for one cycle.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset
//   write_valid    write request present
//   write_ready    FIFO can accept a request this cycle (pending != 2)
//   write_address  target register index 0-7
//   write_data     value to store
//   commit_enable  when low the bank is frozen; the FIFO keeps filling
//   register0..7   register contents, fed straight to the read multiplexer
//   load_enable    one-hot address committed at the last edge, 0 if none
//   pending        FIFO occupancy 0-2
module register_bank_writer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write_valid,
  output logic             write_ready,
  input  logic [2:0]       write_address,
  input  logic [WIDTH-1:0] write_data,
  input  logic             commit_enable,
  output logic [WIDTH-1:0] register0,
  output logic [WIDTH-1:0] register1,
  output logic [WIDTH-1:0] register2,
  output logic [WIDTH-1:0] register3,
  output logic [WIDTH-1:0] register4,
  output logic [WIDTH-1:0] register5,
  output logic [WIDTH-1:0] register6,
  output logic [WIDTH-1:0] register7,
  output logic [7:0]       load_enable,
  output logic [1:0]       pending
);

  // FIFO storage; DEPTH is fixed at 2 so single-bit pointers suffice.
  logic [2:0]       fifo_addr [DEPTH];
  logic [WIDTH-1:0] fifo_data [DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic [WIDTH-1:0] bank [8];
  logic [7:0]       load_q;

  logic             push;
  logic             pop;
  logic [2:0]       head_addr;
  logic [WIDTH-1:0] head_data;
  logic [7:0]       decode;

  // Ready depends on occupancy alone so it never combinationally follows
  // write_valid; a full FIFO refuses the push even on a popping edge.
  assign write_ready = (count != 2'd2);
  assign pending     = count;

  assign push = write_valid & write_ready;
  // No bypass: an empty FIFO cannot commit, even if a push lands this edge.
  assign pop  = commit_enable & (count != 2'd0);

  assign head_addr = fifo_addr[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  always_comb begin
    decode = 8'h00;
    decode[head_addr] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr[i] <= 3'd0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= write_address;
        fifo_data[wr_ptr] <= write_data;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_q <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        bank[i] <= '0;
      end
    end else begin
      load_q <= pop ? decode : 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (pop && decode[i]) begin
          bank[i] <= head_data;
        end
      end
    end
  end

  assign load_enable = load_q;

  assign register0 = bank[0];
  assign register1 = bank[1];
  assign register2 = bank[2];
  assign register3 = bank[3];
  assign register4 = bank[4];
  assign register5 = bank[5];
  assign register6 = bank[6];
  assign register7 = bank[7];

endmodule

// File: tb/tb_register_bank_writer.sv
// tb_register_bank_writer
//   Table-driven directed vectors, hand-written reset sequences and a
//   randomized phase, all checked against a queue/array reference model.
module tb_register_bank_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        write_valid;
  logic        write_ready;
  logic [2:0]  write_address;
  logic [15:0] write_data;
  logic        commit_enable;
  logic [15:0] register0, register1, register2, register3;
  logic [15:0] register4, register5, register6, register7;
  logic [7:0]  load_enable;
  logic [1:0]  pending;

  logic [15:0] regs_dut [8];

  int checks   = 0;
  int failures = 0;

  register_bank_writer #(.WIDTH(16), .DEPTH(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .write_valid   (write_valid),
    .write_ready   (write_ready),
    .write_address (write_address),
    .write_data    (write_data),
    .commit_enable (commit_enable),
    .register0     (register0),
    .register1     (register1),
    .register2     (register2),
    .register3     (register3),
    .register4     (register4),
    .register5     (register5),
    .register6     (register6),
    .register7     (register7),
    .load_enable   (load_enable),
    .pending       (pending)
  );

  always #5 clock = ~clock;

  assign regs_dut[0] = register0;
  assign regs_dut[1] = register1;
  assign regs_dut[2] = register2;
  assign regs_dut[3] = register3;
  assign regs_dut[4] = register4;
  assign regs_dut[5] = register5;
  assign regs_dut[6] = register6;
  assign regs_dut[7] = register7;

  // Reference model: an ordered queue of writes plus the bank contents.
  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } ent_t;

  ent_t        mq [$];
  logic [15:0] mreg [8];
  logic [7:0]  mload;
  bit          last_push;

  typedef struct {
    logic        valid;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        commit;
    logic [1:0]  pend;
    logic [7:0]  load;
    logic        ready;
    int          ridx;
    logic [15:0] rval;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
    mload = 8'h00;
    last_push = 1'b0;
  endtask

  // Applies one rising edge's worth of the write/commit rules to the model.
  task automatic model_edge();
    bit   can_push;
    ent_t e;
    can_push = (mq.size() != 2);
    mload = 8'h00;
    if (commit_enable && mq.size() != 0) begin
      e = mq.pop_front();
      mreg[e.a] = e.d;
      mload = 8'(1 << e.a);
    end
    last_push = write_valid && can_push;
    if (last_push) begin
      e.a = write_address;
      e.d = write_data;
      mq.push_back(e);
    end
  endtask

  task automatic compare_model();
    chk("pending", 32'(pending), 32'(mq.size()));
    chk("write_ready", 32'(write_ready), 32'(mq.size() != 2));
    chk("load_enable", 32'(load_enable), 32'(mload));
    for (int i = 0; i < 8; i++)
      chk($sformatf("register%0d", i), 32'(regs_dut[i]), 32'(mreg[i]));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_model();
  endtask

  task automatic drive(input logic v, input logic [2:0] a, input logic [15:0] d, input logic c);
    write_valid   = v;
    write_address = a;
    write_data    = d;
    commit_enable = c;
  endtask

  initial begin
    // Directed table: inputs applied for one edge, outputs expected after it.
    vt[0]  = '{1, 3'd2, 16'h5555, 1, 2'd1, 8'h00, 1, 2, 16'h0000};
    vt[1]  = '{0, 3'd0, 16'h0000, 1, 2'd0, 8'h04, 1, 2, 16'h5555};
    vt[2]  = '{0, 3'd0, 16'h0000, 1, 2'd0, 8'h00, 1, 0, 16'h0000};
    vt[3]  = '{1, 3'd5, 16'h8843, 0, 2'd1, 8'h00, 1, 5, 16'h0000};
    vt[4]  = '{1, 3'd5, 16'hFFFF, 0, 2'd2, 8'h00, 0, 5, 16'h0000};
    vt[5]  = '{1, 3'd1, 16'h1234, 0, 2'd2, 8'h00, 0, 1, 16'h0000};
    vt[6]  = '{1, 3'd1, 16'h1234, 1, 2'd1, 8'h20, 1, 5, 16'h8843};
    vt[7]  = '{1, 3'd1, 16'h1234, 1, 2'd1, 8'h20, 1, 5, 16'hFFFF};
    vt[8]  = '{0, 3'd0, 16'h0000, 1, 2'd0, 8'h02, 1, 1, 16'h1234};
    vt[9]  = '{1, 3'd0, 16'h1000, 1, 2'd1, 8'h00, 1, 2, 16'h5555};
    for (int k = 1; k < 8; k++)
      vt[9+k] = '{1, 3'(k), 16'(16'h1000 + k), 1, 2'd1, 8'(1 << (k-1)), 1, k-1,
                  16'(16'h1000 + k - 1)};
    vt[17] = '{0, 3'd0, 16'h0000, 1, 2'd0, 8'h80, 1, 7, 16'h1007};
    vt[18] = '{0, 3'd0, 16'h0000, 1, 2'd0, 8'h00, 1, 7, 16'h1007};

    model_reset();
    reset = 1'b0;
    drive(0, 3'd0, 16'h0000, 0);
    #1;
    compare_model();
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].valid, vt[i].addr, vt[i].data, vt[i].commit);
      cycle();
      chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vt[i].pend));
      chk($sformatf("vec%0d_load", i), 32'(load_enable), 32'(vt[i].load));
      chk($sformatf("vec%0d_ready", i), 32'(write_ready), 32'(vt[i].ready));
      chk($sformatf("vec%0d_reg", i), 32'(regs_dut[vt[i].ridx]), 32'(vt[i].rval));
    end

    // Reset mid-operation: two queued writes to register 7 must be dropped.
    drive(1, 3'd7, 16'hAAAA, 0);
    cycle();
    drive(1, 3'd7, 16'hBBBB, 0);
    cycle();
    chk("queued_pending", 32'(pending), 32'd2);
    drive(0, 3'd0, 16'h0000, 0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("midrst_pending", 32'(pending), 32'd0);
    chk("midrst_ready", 32'(write_ready), 32'd1);
    chk("midrst_load", 32'(load_enable), 32'd0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("midrst_register%0d", i), 32'(regs_dut[i]), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(0, 3'd0, 16'h0000, 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("postrst_load", 32'(load_enable), 32'd0);
      chk("postrst_register7", 32'(register7), 32'd0);
    end

    // Randomized traffic; a refused request is held until it is taken.
    drive(0, 3'd0, 16'h0000, 1);
    last_push = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!(write_valid && !last_push)) begin
        write_valid   = ($urandom_range(0, 3) != 0);
        write_address = 3'($urandom_range(0, 7));
        write_data    = 16'($urandom);
      end
      commit_enable = (n % 80 < 60) ? ($urandom_range(0, 4) != 0)
                                    : ($urandom_range(0, 4) == 0);
      cycle();
    end

    // Drain and confirm the model and the bank agree at rest.
    drive(0, 3'd0, 16'h0000, 1);
    for (int i = 0; i < 4; i++) cycle();
    chk("drained_pending", 32'(pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
